// File: rtl/spi_slave_regfile_gen2.sv
// SPI slave with an on-chip register file. SCLK/CS/MOSI are oversampled in the CLK domain.
// The optional sticky framing-error flag is built only when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave_regfile_gen2 #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              FRAME_ERR,
    output logic [1:0]        STATE_DBG
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SR_W  = (DATA_W > 8) ? DATA_W : 8;
    localparam int CNT_W = $clog2(SR_W);
    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_WR, ST_RD} state_t;

    // Sync chains reset to 0 so a CS already low at reset release never looks like a fall.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic sclk_prev_q, cs_prev_q;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SR_W-2:0]    shift_in_q, shift_in_d;
    logic [SR_W-1:0]    shift_nxt;
    logic [7:0]         hdr_word;
    logic [DATA_W-1:0]  data_word;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               miso_q, miso_d;
    logic               pf_q, pf_d;
    logic               wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  host_rdata_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic               frame_err_q, frame_err_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;

    assign shift_nxt = {shift_in_q, mosi_s};
    assign hdr_word  = shift_nxt[7:0];
    assign data_word = shift_nxt[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_in_d = shift_in_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        pf_d       = 1'b0;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = frame_err_q;
`endif
        // Prefetch runs one CLK after addr_q settles on the word to be sent.
        if (pf_q) tx_d = mem_q[addr_q];
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_HDR;
                    bit_cnt_d = '0;
                end
            end
            ST_HDR: begin
                miso_d = 1'b0;
                if (sample_edge) begin
                    shift_in_d = shift_nxt[SR_W-2:0];
                    if (bit_cnt_q == HDR_LAST) begin
                        bit_cnt_d = '0;
                        addr_d    = ADDR_W'(hdr_word);
                        state_d   = hdr_word[7] ? ST_RD : ST_WR;
                        pf_d      = hdr_word[7];
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err_d = 1'b0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_WR: begin
                miso_d = 1'b0;
                if (sample_edge) begin
                    shift_in_d = shift_nxt[SR_W-2:0];
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d = '0;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_word;
                        addr_d    = addr_q + ADDR_ONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                if (shift_edge) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                end
                if (sample_edge) begin
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + ADDR_ONE;
                        pf_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
        endcase
        // CS deasserted mid-frame: drop the partial word and return to idle.
        if (state_q != ST_IDLE && cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            pf_d      = 1'b0;
            wr_stb_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = frame_err_q | (bit_cnt_q != '0);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            addr_q       <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            pf_q         <= 1'b0;
            wr_stb_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            pf_q         <= pf_d;
            wr_stb_q     <= wr_stb_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= mem_q[HOST_ADDR];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_stb_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) frame_err_q <= 1'b0;
        else        frame_err_q <= frame_err_d;
    end
    assign FRAME_ERR = frame_err_q;
`else
    assign FRAME_ERR = 1'b0;
`endif

    assign MISO       = miso_q;
    assign MISO_OE    = RST_N & ~cs_s;
    assign HOST_RDATA = host_rdata_q;
    assign WR_STB     = wr_stb_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign STATE_DBG  = state_q;
endmodule
